// File: rtl/tone_decoder.sv
// tone_decoder: measures the half-period of a square-wave input and
// classifies it into the 8-bit fullnote code (octave*12 + note, 8'hFF = silence).
// A stability filter and a no-edge timeout produce a clean fullnote stream.
module tone_decoder #(
  parameter int TICK_DIV = 256,
  parameter int STABLE   = 3,
  parameter int TIMEOUT  = 8192
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       tone_in,
  output logic [7:0] fullnote,
  output logic       note_valid,
  output logic       locked
);

  localparam int          PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [15:0] TO   = 16'(TIMEOUT);
  localparam logic [3:0]  STB  = 4'(STABLE);
  localparam logic [7:0]  SILENCE = 8'hFF;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_NORM   = 3'd1;
  localparam logic [2:0] S_SCAN   = 3'd2;
  localparam logic [2:0] S_DONE   = 3'd3;
  localparam logic [2:0] S_REJECT = 3'd4;

  // octave-3 half-periods; lower octaves are these shifted left
  function automatic logic [9:0] dtab(input logic [3:0] i);
    case (i)
      4'd0:    dtab = 10'd512;
      4'd1:    dtab = 10'd483;
      4'd2:    dtab = 10'd456;
      4'd3:    dtab = 10'd431;
      4'd4:    dtab = 10'd406;
      4'd5:    dtab = 10'd384;
      4'd6:    dtab = 10'd362;
      4'd7:    dtab = 10'd342;
      4'd8:    dtab = 10'd323;
      4'd9:    dtab = 10'd304;
      4'd10:   dtab = 10'd287;
      default: dtab = 10'd271;
    endcase
  endfunction

  logic        sync1, sync2, sync_d;
  logic        edge_ev;
  logic [PW-1:0] pre;
  logic        tick;
  logic [15:0] hcnt, hcnt_inc;
  logic        armed;
  logic        timeout;
  logic        capture;

  logic [2:0]  state;
  logic [15:0] h;
  logic [1:0]  s;
  logic [1:0]  oct;
  logic [3:0]  idx;
  logic [3:0]  best_idx;
  logic [9:0]  best_err;
  logic [9:0]  dval;
  logic [9:0]  err;
  logic [7:0]  cand;

  logic [7:0]  prev_cand;
  logic [3:0]  match;
  logic [3:0]  new_match;

  // two-flop synchronizer plus a delayed copy for edge detection
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      sync_d <= 1'b0;
    end else begin
      sync1  <= tone_in;
      sync2  <= sync1;
      sync_d <= sync2;
    end
  end

  assign edge_ev = sync2 ^ sync_d;

  // free-running tick prescaler; with TICK_DIV=1 the compare is always true
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)  pre <= '0;
    else if (tick) pre <= '0;
    else           pre <= pre + 1'b1;
  end

  assign tick = (pre == PW'(TICK_DIV - 1));

  // H is the count including the current tick, so with TICK_DIV=1 it equals
  // the clock distance between consecutive edge events
  assign hcnt_inc = (tick && hcnt != TO) ? hcnt + 16'd1 : hcnt;
  assign timeout  = armed && !edge_ev && (hcnt_inc == TO);
  assign capture  = edge_ev && armed && (state == S_IDLE);

  // half-period counter: cleared and armed by every edge, disarmed by timeout
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hcnt  <= '0;
      armed <= 1'b0;
    end else if (edge_ev) begin
      hcnt  <= '0;
      armed <= 1'b1;
    end else if (timeout) begin
      hcnt  <= '0;
      armed <= 1'b0;
    end else if (armed) begin
      hcnt  <= hcnt_inc;
    end
  end

  assign dval = dtab(idx);
  assign err  = (h[9:0] >= dval) ? h[9:0] - dval : dval - h[9:0];
  assign cand = {6'd0, oct} * 8'd12 + {4'd0, best_idx};

  // classifier: normalise into octave 3 range, then nearest-entry scan
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      h        <= '0;
      s        <= '0;
      oct      <= '0;
      idx      <= '0;
      best_idx <= '0;
      best_err <= '1;
    end else begin
      case (state)
        S_IDLE: begin
          if (capture) begin
            h     <= hcnt_inc;
            s     <= 2'd0;
            state <= S_NORM;
          end
        end
        S_NORM: begin
          if (h >= 16'd527) begin
            if (s == 2'd3) state <= S_REJECT;
            else begin
              h <= h >> 1;
              s <= s + 2'd1;
            end
          end else if (h < 16'd264) begin
            state <= S_REJECT;
          end else begin
            oct      <= 2'd3 - s;
            idx      <= 4'd0;
            best_idx <= 4'd0;
            best_err <= '1;
            state    <= S_SCAN;
          end
        end
        S_SCAN: begin
          // strict compare keeps the lower index on a tie
          if (err < best_err) begin
            best_err <= err;
            best_idx <= idx;
          end
          if (idx == 4'd11) state <= S_DONE;
          else              idx   <= idx + 4'd1;
        end
        S_DONE:   state <= S_IDLE;
        S_REJECT: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  assign new_match = (cand != prev_cand) ? 4'd1 :
                     (match >= STB)      ? STB  : match + 4'd1;

  // stability filter and output register; timeout overrides a same-cycle update
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fullnote   <= SILENCE;
      note_valid <= 1'b0;
      locked     <= 1'b0;
      prev_cand  <= SILENCE;
      match      <= '0;
    end else begin
      note_valid <= 1'b0;
      if (timeout) begin
        note_valid <= (fullnote != SILENCE);
        fullnote   <= SILENCE;
        locked     <= 1'b0;
        prev_cand  <= SILENCE;
        match      <= '0;
      end else if (state == S_REJECT) begin
        match <= '0;
      end else if (state == S_DONE) begin
        match     <= new_match;
        prev_cand <= cand;
        if (new_match >= STB && cand != fullnote) begin
          fullnote   <= cand;
          locked     <= 1'b1;
          note_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_tone_decoder.sv
// tb_tone_decoder: table-driven vectors, hand sequences for timeout and
// reset, then randomized half-periods checked against a behavioural model.
module tb_tone_decoder;
  localparam int TO  = 8192;
  localparam int STB = 3;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       tone_in = 1'b0;
  logic [7:0] fullnote;
  logic       note_valid;
  logic       locked;

  tone_decoder #(.TICK_DIV(1), .STABLE(STB), .TIMEOUT(TO)) dut (
    .clock(clock), .reset_n(reset_n), .tone_in(tone_in),
    .fullnote(fullnote), .note_valid(note_valid), .locked(locked)
  );

  always #5 clock = ~clock;

  typedef struct { int hp; int n; int full; int pulses; } vec_t;
  vec_t tbl[16];

  int n_cmp = 0, n_bad = 0;
  int since = 0;
  int obs_q[$];
  int exp_q[$];
  int dt[12] = '{512, 483, 456, 431, 406, 384, 362, 342, 323, 304, 287, 271};
  int m_full = 255, m_prev = 255, m_cnt = 0;
  bit m_armed = 1'b0;

  // record every pulse with the value it announced
  always @(negedge clock) if (reset_n && note_valid) obs_q.push_back(int'(fullnote));

  // octave o accepts h whose value scaled to octave 3 lies in 264..526
  function automatic int classify(int h);
    int o = -1, hn, best = 0, be = 1 << 30, e;
    for (int oc = 3; oc >= 0; oc--) begin
      hn = h / (1 << (3 - oc));
      if (o < 0 && hn >= 264 && hn <= 526) o = oc;
    end
    if (o < 0) return -1;
    hn = h / (1 << (3 - o));
    for (int n = 0; n < 12; n++) begin
      e = (hn > dt[n]) ? hn - dt[n] : dt[n] - hn;
      if (e < be) begin be = e; best = n; end
    end
    return o * 12 + best;
  endfunction

  task automatic model_edge(input int p);
    int c;
    if (!m_armed) begin m_armed = 1'b1; return; end
    c = classify(p);
    if (c < 0) begin m_cnt = 0; return; end
    if (c == m_prev) begin if (m_cnt < STB) m_cnt++; end
    else begin m_prev = c; m_cnt = 1; end
    if (m_cnt == STB && c != m_full) begin m_full = c; exp_q.push_back(c); end
  endtask

  task automatic model_timeout();
    if (m_full != 255) exp_q.push_back(255);
    m_full = 255; m_prev = 255; m_cnt = 0; m_armed = 1'b0;
  endtask

  task automatic model_reset();
    m_full = 255; m_prev = 255; m_cnt = 0; m_armed = 1'b0;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input int exp_full);
    chk({nm, "_full"}, int'(fullnote), exp_full);
    chk({nm, "_locked"}, int'(locked), int'(exp_full != 255));
    chk({nm, "_npulse"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size(); i++)
      if (i < exp_q.size()) chk({nm, "_pval"}, obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  // toggle tone_in p clocks after the previous toggle
  task automatic edge_after(input int p);
    if (p > since) repeat (p - since) @(posedge clock);
    #1 tone_in = ~tone_in;
    since = 0;
    model_edge(p);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clock);
    #2;
    since += n;
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int np, hp, reps, p;
    tbl = '{'{512, 4, 'h24, 1}, '{3072, 3, 'h05, 1}, '{600, 3, 'h21, 1},
            '{100, 1, 'h21, 0}, '{512, 1, 'h21, 0}, '{483, 1, 'h21, 0},
            '{512, 1, 'h21, 0}, '{483, 1, 'h21, 0}, '{1000, 3, 'h18, 1},
            '{271, 3, 'h2F, 1}, '{4000, 3, 'h00, 1}, '{4300, 1, 'h00, 0},
            '{395, 3, 'h28, 1}, '{527, 2, 'h28, 0}, '{264, 3, 'h2F, 1},
            '{526, 3, 'h24, 1}};

    repeat (3) @(posedge clock);
    #2;
    chk("reset_full", int'(fullnote), 255);
    chk("reset_nv", int'(note_valid), 0);
    chk("reset_locked", int'(locked), 0);
    reset_n = 1'b1;
    model_reset();
    since = 0;

    // table vectors: state carries over from one record to the next
    for (int i = 0; i < 16; i++) begin
      for (int e = 0; e < tbl[i].n; e++) edge_after(tbl[i].hp);
      wait_clk(40);
      np = obs_q.size();
      chk($sformatf("tbl%0d_pulses", i), np, tbl[i].pulses);
      chk_out($sformatf("tbl%0d", i), tbl[i].full);
    end

    // hold the input: silence appears exactly TIMEOUT clocks after the edge
    wait_clk(8190 - since);
    chk_out("pre_timeout", 'h24);
    wait_clk(6);
    model_timeout();
    chk_out("timeout", 255);

    // after timeout: arming edge, then alternating notes never settle
    edge_after(512);
    for (int k = 0; k < 3; k++) begin
      edge_after(512);
      edge_after(483);
    end
    wait_clk(40);
    chk_out("alternate", 255);
    edge_after(100);
    wait_clk(40);
    chk_out("short", 255);
    for (int k = 0; k < 3; k++) edge_after(512);
    wait_clk(40);
    chk_out("relock", 'h24);

    // reset asserted while the classifier is scanning
    edge_after(512);
    repeat (9) @(posedge clock);
    #3 reset_n = 1'b0;
    #1;
    chk("midscan_full", int'(fullnote), 255);
    chk("midscan_nv", int'(note_valid), 0);
    chk("midscan_locked", int'(locked), 0);
    tone_in = 1'b0;
    repeat (3) @(posedge clock);
    #2 reset_n = 1'b1;
    model_reset();
    exp_q.delete();
    since = 0;
    wait_clk(30);
    chk_out("post_reset", 255);
    for (int k = 0; k < 3; k++) edge_after(512);
    wait_clk(40);
    chk_out("rst_3edges", 255);
    edge_after(512);
    wait_clk(40);
    chk_out("rst_4edges", 'h24);

    // randomized groups of repeated half-periods with occasional jitter
    for (int g = 0; g < 10; g++) begin
      hp = $urandom_range(64, 1200);
      reps = $urandom_range(1, 4);
      for (int r = 0; r < reps; r++) begin
        p = hp;
        if ($urandom_range(0, 3) == 0) p = hp + $urandom_range(0, 3);
        edge_after(p);
      end
      wait_clk(40);
      chk_out($sformatf("rand%0d", g), m_full);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
